pool2d_stream: RTL and testbench
================================

// Module: pool2d_stream
// PURPOSE
//  Parametrised 2x2/stride-2 pooling on a raster-order stream of conv outputs, CH channels in parallel.
//  Generates its own row/column position, replacing the hard-coded cnt->sel decode of the previous block.
//  Adds a selectable max/avg mode, per-pixel output, packed pooled-row output and frame wrap-around.
//  Sits between the conv array output and the linear-layer input buffer.
// PARAMETERS
//  CH     3  channels processed in parallel
//  DW     8  data width per channel, unsigned
//  IMG_W  6  conv map width; even, >=2
//  IMG_H  6  conv map height; even, >=2
//  MODE   0  0 = max pool, 1 = average pool (round half up)
// PORTS
//  clk      in   1           clock, rising edge
//  rst_n    in   1           async active-low reset
//  clr      in   1           sync clear: counters, buffers and outputs -> reset state
//  in_vld   in   1           in_data valid this cycle; gaps allowed
//  in_data  in   CH*DW       channel c at [c*DW +: DW]
//  out_vld  out  1           one-cycle pulse: out_data valid
//  out_data out  CH*DW       pooled pixel, same channel packing
//  row_vld  out  1           one-cycle pulse: row_data holds a complete pooled row
//  row_data out  CH*OW*DW    OW=IMG_W/2; channel c block at [c*OW*DW +: OW*DW], pixel 0 in LSBs
//  frm_done out  1           pulse with the last out_vld of a frame
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low on rst_n. All regs and outputs reset to 0.
//  - col (0..IMG_W-1) and row (0..IMG_H-1) advance only on in_vld.
//    col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
//  - Per channel, on in_vld:
//      even col: hold px in pair register p.
//      odd col, even row: hbuf[col>>1] <= f(p, px).
//      odd col, odd row:  result = f(hbuf[col>>1], f(p, px)).
//  - f = max in MODE 0. MODE 1 accumulates DW+2-bit sums; result = (sum4+2)>>2 (never exceeds 2^DW-1).
//  - Latency: out_vld/out_data registered 1 cycle after the in_vld beat at odd row, odd col.
//    out_data holds its value until the next out_vld.
//  - row_data: result written to slot col>>1. row_vld pulses in the same cycle as the out_vld for slot OW-1.
//    row_data is stable until the next row completes.
//  - frm_done: asserted with the out_vld of (IMG_H-1, IMG_W-1); the next beat starts a new frame at (0,0).
//  - clr has priority over in_vld in the same cycle. A frame interrupted by clr or rst_n yields no partial output.
//  - No backpressure: downstream must accept every out_vld/row_vld pulse.
//  - Elaboration error if IMG_W or IMG_H is odd or < 2.
// STRUCTURE
//  - Package pool_pkg: MODE_MAX=0 / MODE_AVG=1 constants; function pool_f(a, b, mode).
//  - Sub-module pool_lane (one channel: p, hbuf[OW], row slots, f), generate-looped CH times.
//  - Top level holds col/row counters, the odd/last decode and valid pulse registers.
// TESTING
//  1 MODE0, CH=3, 6x6 frame; ch0 = raster index 0..35 -> out ch0 = 7,9,11,19,21,23,31,33,35.
//    row_vld fires 3 times; first row_data ch0 = {11,9,7}.
//  2 MODE1, all pixels of each window = {10,11,12,13} -> out = 12 ((46+2)>>2).
//    All-255 window -> 255, no overflow.
//  3 Random in_vld gaps (~50% duty): results identical to the gap-free run.
//    out_vld exactly 1 cycle after the qualifying beat.
//  4 Two back-to-back frames with no idle cycle: 18 out_vld pulses, frm_done twice, second frame correct.
//  5 clr asserted with in_vld at row 3 col 2, then a fresh frame: no stale outputs; first result from the new data only.
//  6 rst_n dropped mid-frame, asynchronously between edges: outputs 0 immediately; frame restarts at (0,0).

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared pooling mode constants and the pairwise pooling operator.
//   MODE_MAX / MODE_AVG select the operator; pool_f(a, b, mode) returns max(a, b) or a + b.
package pool_pkg;
  localparam int MODE_MAX = 0;
  localparam int MODE_AVG = 1;
  function automatic logic [31:0] pool_f(input logic [31:0] a, input logic [31:0] b, input int mode);
    return (mode == MODE_AVG) ? a + b : (a > b ? a : b);
  endfunction
endpackage

// File: rtl/pool_lane.sv
// pool_lane: one channel of 2x2/stride-2 pooling.
//   clk, rst_n (async, active-low), clr (sync clear)
//   i_pair : latch the even-column pixel; i_hor : store the horizontal pair result (even row)
//   i_ver  : produce the window result (odd row); i_last : this result completes the pooled row
//   i_slot : pooled column index; i_px : pixel
//   o_data : last pooled pixel; o_row : last complete pooled row, slot 0 in LSBs
module pool_lane
  import pool_pkg::*;
#(
  parameter int DW   = 8,
  parameter int OW   = 3,
  parameter int MODE = MODE_MAX,
  parameter int IW   = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             i_pair,
  input  logic             i_hor,
  input  logic             i_ver,
  input  logic             i_last,
  input  logic [IW-1:0]    i_slot,
  input  logic [DW-1:0]    i_px,
  output logic [DW-1:0]    o_data,
  output logic [OW*DW-1:0] o_row
);
  // Two extra bits hold a four-pixel sum in average mode.
  localparam int SW = DW + 2;
  logic [SW-1:0]    r_p;
  logic [SW-1:0]    r_hbuf [OW];
  logic [DW-1:0]    r_stg [OW];
  logic [DW-1:0]    r_out;
  logic [OW*DW-1:0] r_row;
  logic [SW-1:0]    w_h;
  logic [SW-1:0]    w_v;
  logic [DW-1:0]    w_res;
  logic [OW*DW-1:0] w_row;
  assign w_h   = SW'(pool_f(32'(r_p), 32'(i_px), MODE));
  assign w_v   = SW'(pool_f(32'(r_hbuf[i_slot]), 32'(w_h), MODE));
  // Round half up: (sum + 2) >> 2 stays within DW bits since sum <= 4*(2^DW-1).
  assign w_res = (MODE == MODE_AVG) ? DW'((w_v + SW'(2)) >> 2) : w_v[DW-1:0];
  // Published row = staged slots with the slot being written replaced by the new result,
  // so row output only changes when a row completes.
  always_comb begin
    w_row = '0;
    for (int k = 0; k < OW; k++) w_row[k*DW +: DW] = (IW'(k) == i_slot) ? w_res : r_stg[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p    <= '0;
      r_hbuf <= '{default: '0};
      r_stg  <= '{default: '0};
      r_out  <= '0;
      r_row  <= '0;
    end else if (clr) begin
      r_p    <= '0;
      r_hbuf <= '{default: '0};
      r_stg  <= '{default: '0};
      r_out  <= '0;
      r_row  <= '0;
    end else begin
      if (i_pair) r_p <= SW'(i_px);
      if (i_hor) r_hbuf[i_slot] <= w_h;
      if (i_ver) begin
        r_out         <= w_res;
        r_stg[i_slot] <= w_res;
        if (i_last) r_row <= w_row;
      end
    end
  end
  assign o_data = r_out;
  assign o_row  = r_row;
endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream: 2x2/stride-2 max/avg pooling over a raster-order stream, CH channels in parallel.
//   clk, rst_n (async, active-low), clr (sync clear of counters, buffers, outputs)
//   in_vld/in_data : input beat, channel c at [c*DW +: DW]
//   out_vld/out_data : pooled pixel pulse; row_vld/row_data : complete pooled row pulse
//   frm_done : pulses with the last pooled pixel of a frame
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int MODE  = MODE_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_vld,
  input  logic [CH*DW-1:0]         in_data,
  output logic                     out_vld,
  output logic [CH*DW-1:0]         out_data,
  output logic                     row_vld,
  output logic [CH*(IMG_W/2)*DW-1:0] row_data,
  output logic                     frm_done
);
  localparam int OW = IMG_W / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int IW = (OW > 1) ? $clog2(OW) : 1;
  if (IMG_W < 2 || IMG_W % 2 != 0 || IMG_H < 2 || IMG_H % 2 != 0) begin : g_bad_size
    $error("pool2d_stream: IMG_W and IMG_H must be even and >= 2");
  end
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_ovld;
  logic          r_rvld;
  logic          r_fdone;
  logic          w_lcol;
  logic          w_lrow;
  logic          w_pair;
  logic          w_hor;
  logic          w_ver;
  logic [IW-1:0] w_slot;
  assign w_lcol = r_col == CW'(IMG_W - 1);
  assign w_lrow = r_row == RW'(IMG_H - 1);
  assign w_pair = in_vld & ~r_col[0];
  assign w_hor  = in_vld & r_col[0] & ~r_row[0];
  assign w_ver  = in_vld & r_col[0] & r_row[0];
  assign w_slot = IW'(r_col >> 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_ovld  <= 1'b0;
      r_rvld  <= 1'b0;
      r_fdone <= 1'b0;
    end else if (clr) begin
      r_col   <= '0;
      r_row   <= '0;
      r_ovld  <= 1'b0;
      r_rvld  <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      if (in_vld) begin
        r_col <= w_lcol ? '0 : r_col + CW'(1);
        if (w_lcol) r_row <= w_lrow ? '0 : r_row + RW'(1);
      end
      r_ovld  <= w_ver;
      r_rvld  <= w_ver & w_lcol;
      r_fdone <= w_ver & w_lcol & w_lrow;
    end
  end
  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool_lane #(.DW(DW), .OW(OW), .MODE(MODE), .IW(IW)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .i_pair (w_pair),
      .i_hor  (w_hor),
      .i_ver  (w_ver),
      .i_last (w_lcol),
      .i_slot (w_slot),
      .i_px   (in_data[c*DW +: DW]),
      .o_data (out_data[c*DW +: DW]),
      .o_row  (row_data[c*OW*DW +: OW*DW])
    );
  end
  assign out_vld  = r_ovld;
  assign row_vld  = r_rvld;
  assign frm_done = r_fdone;
endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: directed checks of pool2d_stream in max and average mode on a 6x6, 3-channel stream.
module tb_pool2d_stream;
  localparam int W = 6;
  localparam int H = 6;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_vld;
  logic [23:0] in_data;
  logic        mv, mr, mf, av, ar, af;
  logic [23:0] md, ad;
  logic [71:0] mrow, arow;
  logic [23:0] last_m, last_a;
  int n_tests = 0;
  int n_fail  = 0;
  int n_ov    = 0;
  int n_fd    = 0;
  always #5 clk = ~clk;
  pool2d_stream #(.CH(3), .DW(8), .IMG_W(W), .IMG_H(H), .MODE(0)) u_max (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .out_vld(mv), .out_data(md), .row_vld(mr), .row_data(mrow), .frm_done(mf)
  );
  pool2d_stream #(.CH(3), .DW(8), .IMG_W(W), .IMG_H(H), .MODE(1)) u_avg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .out_vld(av), .out_data(ad), .row_vld(ar), .row_data(arow), .frm_done(af)
  );
  // kind 0: ch0 = raster index, ch1 = 100 + index, ch2 = 200 - index
  // kind 1: every window of ch0 is {10,11,12,13}; ch1 all 255; ch2 all 0
  function automatic logic [23:0] pix(input int kind, input int r, input int c);
    int i;
    i = r * W + c;
    return (kind == 0) ? {8'(200 - i), 8'(100 + i), 8'(i)} : {8'h00, 8'hFF, 8'(10 + 2 * (r % 2) + (c % 2))};
  endfunction
  // Hand-derived window results, t = raster index of the window's top-left pixel.
  function automatic logic [23:0] exp_px(input int kind, input int mode, input int wr, input int wc);
    int t;
    t = wr * 12 + wc * 2;
    if (kind == 0) return (mode == 0) ? {8'(200 - t), 8'(107 + t), 8'(t + 7)} : {8'(197 - t), 8'(104 + t), 8'(t + 4)};
    return (mode == 0) ? {8'h00, 8'hFF, 8'd13} : {8'h00, 8'hFF, 8'd12};
  endfunction
  function automatic logic [71:0] exp_row(input int kind, input int mode, input int wr);
    logic [71:0] e;
    logic [23:0] p;
    e = '0;
    for (int wc = 0; wc < 3; wc++) begin
      p = exp_px(kind, mode, wr, wc);
      for (int ch = 0; ch < 3; ch++) e[ch*24 + wc*8 +: 8] = p[ch*8 +: 8];
    end
    return e;
  endfunction
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    n_ov += int'(mv);
    n_fd += int'(mf);
    chk("idle_out_vld", 72'(mv), 72'(0));
    chk("idle_hold_max", 72'(md), 72'(last_m));
    chk("idle_hold_avg", 72'(ad), 72'(last_a));
  endtask
  task automatic beat(input logic [23:0] d, input logic c);
    in_vld  = 1'b1;
    in_data = d;
    clr     = c;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    clr    = 1'b0;
    n_ov += int'(mv);
    n_fd += int'(mf);
  endtask
  task automatic run(input int kind, input bit gaps, input int nbeats);
    int r, c;
    bit q;
    for (int i = 0; i < nbeats; i++) begin
      r = i / W;
      c = i % W;
      if (gaps) repeat ($urandom_range(0, 1)) idle();
      beat(pix(kind, r, c), 1'b0);
      q = (r % 2 == 1) && (c % 2 == 1);
      chk("out_vld_max", 72'(mv), 72'(q));
      chk("out_vld_avg", 72'(av), 72'(q));
      if (q) begin
        last_m = exp_px(kind, 0, r / 2, c / 2);
        last_a = exp_px(kind, 1, r / 2, c / 2);
        chk("out_data_max", 72'(md), 72'(last_m));
        chk("out_data_avg", 72'(ad), 72'(last_a));
      end
      chk("row_vld_max", 72'(mr), 72'(q && c == W - 1));
      chk("row_vld_avg", 72'(ar), 72'(q && c == W - 1));
      if (q && c == W - 1) begin
        chk("row_data_max", mrow, exp_row(kind, 0, r / 2));
        chk("row_data_avg", arow, exp_row(kind, 1, r / 2));
      end
      chk("frm_done_max", 72'(mf), 72'(q && r == H - 1 && c == W - 1));
      chk("frm_done_avg", 72'(af), 72'(q && r == H - 1 && c == W - 1));
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_out_vld"}, 72'(mv), 72'(0));
    chk({tag, "_out_data_max"}, 72'(md), 72'(0));
    chk({tag, "_out_data_avg"}, 72'(ad), 72'(0));
    chk({tag, "_row_data_max"}, mrow, 72'(0));
    chk({tag, "_row_data_avg"}, arow, 72'(0));
    chk({tag, "_frm_done"}, 72'(mf), 72'(0));
  endtask
  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    last_m  = '0;
    last_a  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    // 1 + 2: max/avg on ramp data, then constant windows incl. all-255
    run(0, 1'b0, W * H);
    chk("t1_out_count", 72'(n_ov), 72'(9));
    chk("t1_frm_count", 72'(n_fd), 72'(1));
    run(1, 1'b0, W * H);
    // 3: random gaps
    run(0, 1'b1, W * H);
    // 4: back-to-back frames
    n_ov = 0;
    n_fd = 0;
    run(1, 1'b0, W * H);
    run(0, 1'b0, W * H);
    chk("t4_out_count", 72'(n_ov), 72'(18));
    chk("t4_frm_count", 72'(n_fd), 72'(2));
    // 5: clr together with in_vld at row 3 col 2, then a fresh frame
    run(0, 1'b0, 20);
    beat(pix(0, 3, 2), 1'b1);
    chk_zero("clr");
    last_m = '0;
    last_a = '0;
    run(1, 1'b0, W * H);
    // 6: asynchronous reset mid-frame, between clock edges
    run(0, 1'b0, 14);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    last_m = '0;
    last_a = '0;
    #2;
    rst_n = 1'b1;
    run(0, 1'b0, W * H);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
